// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 app-port master: command codes and FSM state encoding.
package ddr3_app_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'd0;
  localparam logic [2:0] APP_CMD_RD = 3'd1;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    WR      = 3'd2,
    RD      = 3'd3,
    RD_WAIT = 3'd4,
    RESP    = 3'd5
  } app_state_e;

endpackage

// File: rtl/ddr3_app_master_if.sv
// Front-end request/response bus plus DDR3 IP app port, seen from the master (DUT) and its environment.
interface ddr3_app_master_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int MASK_W = DATA_W / 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_we;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_calib_complete;
  logic              cmd_ready;
  logic [2:0]        cmd;
  logic              cmd_en;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        app_burst_number;
  logic              wr_data_rdy;
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_en;
  logic              wr_data_end;
  logic [MASK_W-1:0] wr_data_mask;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_data_end;
  logic              sr_req;
  logic              ref_req;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata,
    input  init_calib_complete, cmd_ready, wr_data_rdy, rd_data, rd_data_valid, rd_data_end,
    output cmd, cmd_en, addr, app_burst_number, wr_data, wr_data_en, wr_data_end,
    output wr_data_mask, sr_req, ref_req
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata,
    output init_calib_complete, cmd_ready, wr_data_rdy, rd_data, rd_data_valid, rd_data_end,
    input  cmd, cmd_en, addr, app_burst_number, wr_data, wr_data_en, wr_data_end,
    input  wr_data_mask, sr_req, ref_req
  );

endinterface

// File: rtl/ddr3_app_master.sv
// Single-outstanding DDR3 app-port initiator: one 128-bit read or write per front-end request,
// sequencing command, write-data and read-return handshakes and emitting one response pulse.
module ddr3_app_master
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int MASK_W     = DATA_W / 8,
  parameter int RD_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  ddr3_app_master_if.master bus
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

  app_state_e state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              cmd_en_q, cmd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              cmd_done_q, cmd_done_d;
  logic              wr_done_q, wr_done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic             accept_s;
  logic             cmd_hs_s;
  logic             wr_hs_s;
  logic             timeout_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign accept_s  = (state_q == IDLE) && bus.req_valid;
  assign cmd_hs_s  = cmd_en_q && bus.cmd_ready;
  assign wr_hs_s   = wr_en_q && bus.wr_data_rdy;
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // A return beat arriving on the timeout cycle still counts as data.
  assign timeout_s = (cnt_inc_s == CNT_MAX) && !bus.rd_data_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (bus.init_calib_complete) state_d = IDLE; else state_d = INIT;
      IDLE:    if (bus.req_valid) state_d = bus.req_we ? WR : RD; else state_d = IDLE;
      WR:      if (cmd_done_q && wr_done_q) state_d = RESP; else state_d = WR;
      RD:      if (cmd_hs_s) state_d = RD_WAIT; else state_d = RD;
      RD_WAIT: if (bus.rd_data_valid || timeout_s) state_d = RESP; else state_d = RD_WAIT;
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Output and datapath next values; strobes are derived from the state being entered.
  always_comb begin
    we_d        = we_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept_s) begin
      we_d       = bus.req_we;
      addr_d     = bus.req_addr;
      cmd_d      = bus.req_we ? APP_CMD_WR : APP_CMD_RD;
      wdata_d    = bus.req_wdata;
      wmask_d    = bus.req_wmask;
      cmd_done_d = 1'b0;
      wr_done_d  = 1'b0;
    end else begin
      cmd_done_d = cmd_done_q || cmd_hs_s;
      wr_done_d  = wr_done_q || wr_hs_s;
    end
    case (state_q)
      WR:      rsp_err_d = 1'b0;
      RD:      cnt_d = {CNT_W{1'b0}};
      RD_WAIT: begin
        cnt_d = cnt_inc_s;
        if (bus.rd_data_valid) begin
          rsp_rdata_d = bus.rd_data;
          rsp_err_d   = 1'b0;
        end else if (timeout_s) begin
          rsp_err_d = 1'b1;
        end else begin
          rsp_err_d = rsp_err_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_we_d    = (state_d == RESP) ? we_q : rsp_we_q;
    cmd_en_d    = ((state_d == WR) || (state_d == RD)) && !cmd_done_d;
    wr_en_d     = (state_d == WR) && !wr_done_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      cmd_q       <= APP_CMD_WR;
      wdata_q     <= {DATA_W{1'b0}};
      wmask_q     <= {MASK_W{1'b0}};
      cmd_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      cmd_done_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cmd_en_q    <= cmd_en_d;
      wr_en_q     <= wr_en_d;
      cmd_done_q  <= cmd_done_d;
      wr_done_q   <= wr_done_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_we           = rsp_we_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.rsp_rdata        = rsp_rdata_q;
  assign bus.cmd              = cmd_q;
  assign bus.cmd_en           = cmd_en_q;
  assign bus.addr             = addr_q;
  assign bus.app_burst_number = 6'd0;
  assign bus.wr_data          = wdata_q;
  assign bus.wr_data_en       = wr_en_q;
  assign bus.wr_data_end      = wr_en_q;
  assign bus.wr_data_mask     = wmask_q;
  assign bus.sr_req           = 1'b0;
  assign bus.ref_req          = 1'b0;

endmodule
